// File: rtl/pipe_ctrl_unit_if.sv
// ID-stage inputs and per-stage control outputs of pipe_ctrl_unit.
// CTRL_PERF_CNT_EN adds the stall/flush counter outputs.
interface pipe_ctrl_unit_if #(
  parameter int REG_AW = 5
);
  logic [6:0]        Op_i;
  logic              Valid_i;
  logic [REG_AW-1:0] Rs1_i;
  logic [REG_AW-1:0] Rs2_i;
  logic [REG_AW-1:0] Rd_i;
  logic              Flush_i;
  logic              Stall_o;
  logic [1:0]        ALUOp_o;
  logic              ALUSrc_o;
  logic              Branch_o;
  logic [REG_AW-1:0] EX_rd_o;
  logic              MemRead_o;
  logic              MemWrite_o;
  logic              MEM_RegWrite_o;
  logic [REG_AW-1:0] MEM_rd_o;
  logic              RegWrite_o;
  logic              MemtoReg_o;
  logic [REG_AW-1:0] WB_rd_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0]       StallCnt_o;
  logic [31:0]       FlushCnt_o;
`endif

  modport master (
    output Op_i, Valid_i, Rs1_i, Rs2_i, Rd_i, Flush_i,
    input  Stall_o, ALUOp_o, ALUSrc_o, Branch_o, EX_rd_o,
           MemRead_o, MemWrite_o, MEM_RegWrite_o, MEM_rd_o,
           RegWrite_o, MemtoReg_o, WB_rd_o
`ifdef CTRL_PERF_CNT_EN
           , StallCnt_o, FlushCnt_o
`endif
  );

  modport slave (
    input  Op_i, Valid_i, Rs1_i, Rs2_i, Rd_i, Flush_i,
    output Stall_o, ALUOp_o, ALUSrc_o, Branch_o, EX_rd_o,
           MemRead_o, MemWrite_o, MEM_RegWrite_o, MEM_rd_o,
           RegWrite_o, MemtoReg_o, WB_rd_o
`ifdef CTRL_PERF_CNT_EN
           , StallCnt_o, FlushCnt_o
`endif
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined RISC-V main control: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall and flush bubbles. Optional stall/flush counters via CTRL_PERF_CNT_EN.
module pipe_ctrl_unit #(
  parameter int REG_AW       = 5,
  parameter bit LOAD_USE_DET = 1'b1
) (
  input logic             clk_i,
  input logic             rst_i,
  pipe_ctrl_unit_if.slave bus
);
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_I_ALU  = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;

  ctrl_t             dec_ctrl;
  logic              dec_known, use_rs1, use_rs2;
  logic              hazard, stall, bubble;

  ctrl_t             idex_ctrl_d, idex_ctrl_q, exmem_ctrl_d, exmem_ctrl_q, memwb_ctrl_d, memwb_ctrl_q;
  logic [REG_AW-1:0] idex_rd_d, idex_rd_q, exmem_rd_d, exmem_rd_q, memwb_rd_d, memwb_rd_q;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    dec_ctrl  = '0;
    dec_known = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    if (bus.Valid_i) begin
      unique case (bus.Op_i)
        OP_R:      begin dec_ctrl = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; dec_known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OP_I_ALU:  begin dec_ctrl = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; dec_known = 1'b1; use_rs1 = 1'b1; end
        OP_LOAD:   begin dec_ctrl = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; dec_known = 1'b1; use_rs1 = 1'b1; end
        OP_STORE:  begin dec_ctrl = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; dec_known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OP_BRANCH: begin dec_ctrl = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; dec_known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        default:   ;
      endcase
    end
  end

  // The load in EX cannot forward in time to a dependent instruction in ID.
  always_comb begin
    hazard = LOAD_USE_DET && idex_ctrl_q.mem_read && (idex_rd_q != '0) &&
             ((use_rs1 && (idex_rd_q == bus.Rs1_i)) || (use_rs2 && (idex_rd_q == bus.Rs2_i)));
    stall  = hazard && !bus.Flush_i;
    bubble = stall || bus.Flush_i || !dec_known;
  end

  always_comb begin
    idex_ctrl_d  = bubble ? '0 : dec_ctrl;
    idex_rd_d    = bubble ? '0 : bus.Rd_i;
    exmem_ctrl_d = idex_ctrl_q;
    exmem_rd_d   = idex_rd_q;
    memwb_ctrl_d = exmem_ctrl_q;
    memwb_rd_d   = exmem_rd_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_ctrl_q  <= '0;
      idex_rd_q    <= '0;
      exmem_ctrl_q <= '0;
      exmem_rd_q   <= '0;
      memwb_ctrl_q <= '0;
      memwb_rd_q   <= '0;
    end else begin
      idex_ctrl_q  <= idex_ctrl_d;
      idex_rd_q    <= idex_rd_d;
      exmem_ctrl_q <= exmem_ctrl_d;
      exmem_rd_q   <= exmem_rd_d;
      memwb_ctrl_q <= memwb_ctrl_d;
      memwb_rd_q   <= memwb_rd_d;
    end
  end

  assign bus.Stall_o        = stall;
  assign bus.ALUOp_o        = idex_ctrl_q.alu_op;
  assign bus.ALUSrc_o       = idex_ctrl_q.alu_src;
  assign bus.Branch_o       = idex_ctrl_q.branch;
  assign bus.EX_rd_o        = idex_rd_q;
  assign bus.MemRead_o      = exmem_ctrl_q.mem_read;
  assign bus.MemWrite_o     = exmem_ctrl_q.mem_write;
  assign bus.MEM_RegWrite_o = exmem_ctrl_q.reg_write;
  assign bus.MEM_rd_o       = exmem_rd_q;
  assign bus.RegWrite_o     = memwb_ctrl_q.reg_write;
  assign bus.MemtoReg_o     = memwb_ctrl_q.mem_to_reg;
  assign bus.WB_rd_o        = memwb_rd_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    flush_cnt_d = (bus.Flush_i && (flush_cnt_q != '1)) ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.StallCnt_o = stall_cnt_q;
  assign bus.FlushCnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: expected ID/EX entries are queued as each
// instruction is driven and compared as they appear in EX, MEM and WB.
module tb_pipe_ctrl_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.REG_AW(5)) bus ();
  pipe_ctrl_unit #(.REG_AW(5), .LOAD_USE_DET(1'b1)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic [4:0] rd;
  } ent_t;

  ent_t sb[$];
  int   tests_run = 0;
  int   failures  = 0;

  // Returns {known, alu_op[1:0], alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, use1, use2}.
  function automatic logic [10:0] model_decode(input logic [6:0] op, input logic valid);
    if (!valid) return 11'b0;
    case (op)
      7'd51:   return 11'b1_10_0_1_0_0_0_0_1_1;
      7'd19:   return 11'b1_11_1_1_0_0_0_0_1_0;
      7'd3:    return 11'b1_00_1_1_1_0_1_0_1_0;
      7'd35:   return 11'b1_00_1_0_0_1_0_0_1_1;
      7'd99:   return 11'b1_01_0_0_0_0_0_1_1_1;
      default: return 11'b0;
    endcase
  endfunction

  task automatic sb_clear();
    sb.delete();
    for (int i = 0; i < 3; i++) sb.push_back('0);
  endtask

  task automatic drive(input logic [6:0] op, input logic valid, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic flush);
    bus.Op_i = op; bus.Valid_i = valid; bus.Rs1_i = rs1;
    bus.Rs2_i = rs2; bus.Rd_i = rd; bus.Flush_i = flush;
  endtask

  // One ID cycle: drive, check Stall_o against the model, queue the expected ID/EX entry,
  // clock, then compare the EX, MEM and WB stages against the scoreboard.
  task automatic step(input logic [6:0] op, input logic valid, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic flush,
                      output logic stall_seen);
    logic [10:0] d;
    ent_t        idex, nxt, e_ex, e_mem, e_wb;
    logic        exp_stall;
    @(negedge clk);
    drive(op, valid, rs1, rs2, rd, flush);
    #1;
    d    = model_decode(op, valid);
    idex = sb[2];
    exp_stall = idex.mem_read && (idex.rd != 5'd0) && !flush &&
                ((d[1] && idex.rd == rs1) || (d[0] && idex.rd == rs2));
    tests_run++;
    if (bus.Stall_o !== exp_stall) begin
      failures++;
      $display("FAIL stall op=%0d rs1=%0d rs2=%0d: got %b want %b", op, rs1, rs2, bus.Stall_o, exp_stall);
    end
    stall_seen = bus.Stall_o;
    nxt = (exp_stall || flush || !d[10]) ? ent_t'(0) : {d[9:2], rd};
    sb.push_back(nxt);
    void'(sb.pop_front());
    @(posedge clk);
    #1;
    e_ex = sb[2]; e_mem = sb[1]; e_wb = sb[0];
    tests_run++;
    if ({bus.ALUOp_o, bus.ALUSrc_o, bus.Branch_o, bus.EX_rd_o} !==
        {e_ex.alu_op, e_ex.alu_src, e_ex.branch, e_ex.rd}) begin
      failures++;
      $display("FAIL ex_stage: got aluop=%b src=%b br=%b rd=%0d want aluop=%b src=%b br=%b rd=%0d",
               bus.ALUOp_o, bus.ALUSrc_o, bus.Branch_o, bus.EX_rd_o,
               e_ex.alu_op, e_ex.alu_src, e_ex.branch, e_ex.rd);
    end
    tests_run++;
    if ({bus.MemRead_o, bus.MemWrite_o, bus.MEM_RegWrite_o, bus.MEM_rd_o} !==
        {e_mem.mem_read, e_mem.mem_write, e_mem.reg_write, e_mem.rd}) begin
      failures++;
      $display("FAIL mem_stage: got mr=%b mw=%b rw=%b rd=%0d want mr=%b mw=%b rw=%b rd=%0d",
               bus.MemRead_o, bus.MemWrite_o, bus.MEM_RegWrite_o, bus.MEM_rd_o,
               e_mem.mem_read, e_mem.mem_write, e_mem.reg_write, e_mem.rd);
    end
    tests_run++;
    if ({bus.RegWrite_o, bus.MemtoReg_o, bus.WB_rd_o} !== {e_wb.reg_write, e_wb.mem_to_reg, e_wb.rd}) begin
      failures++;
      $display("FAIL wb_stage: got rw=%b m2r=%b rd=%0d want rw=%b m2r=%b rd=%0d",
               bus.RegWrite_o, bus.MemtoReg_o, bus.WB_rd_o, e_wb.reg_write, e_wb.mem_to_reg, e_wb.rd);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(7'd3, 1'b1, 5'd1, 5'd1, 5'd1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    drive(7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    sb_clear();
  endtask

  task automatic test_reset();
    logic s;
    apply_reset();
    #1;
    tests_run++;
    if ({bus.Stall_o, bus.ALUOp_o, bus.ALUSrc_o, bus.Branch_o, bus.EX_rd_o, bus.MemRead_o,
         bus.MemWrite_o, bus.MEM_RegWrite_o, bus.MEM_rd_o, bus.RegWrite_o, bus.MemtoReg_o,
         bus.WB_rd_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: some output nonzero after reset (ex_rd=%0d aluop=%b)",
               bus.EX_rd_o, bus.ALUOp_o);
    end
    step(7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, s);
  endtask

  task automatic test_r_then_i();
    logic s;
    step(7'd51, 1'b1, 5'd1, 5'd2, 5'd5, 1'b0, s);
    tests_run++;
    if ({bus.ALUOp_o, bus.ALUSrc_o, bus.EX_rd_o} !== {2'b10, 1'b0, 5'd5}) begin
      failures++;
      $display("FAIL r_in_ex: got aluop=%b src=%b rd=%0d want 10/0/5", bus.ALUOp_o, bus.ALUSrc_o, bus.EX_rd_o);
    end
    step(7'd19, 1'b1, 5'd3, 5'd4, 5'd6, 1'b0, s);
    tests_run++;
    if ({bus.ALUOp_o, bus.ALUSrc_o} !== {2'b11, 1'b1}) begin
      failures++;
      $display("FAIL i_in_ex: got aluop=%b src=%b want 11/1", bus.ALUOp_o, bus.ALUSrc_o);
    end
    step(7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, s);
    tests_run++;
    if ({bus.RegWrite_o, bus.MemtoReg_o, bus.WB_rd_o} !== {1'b1, 1'b0, 5'd5}) begin
      failures++;
      $display("FAIL r_in_wb: got rw=%b m2r=%b rd=%0d want 1/0/5", bus.RegWrite_o, bus.MemtoReg_o, bus.WB_rd_o);
    end
  endtask

  task automatic test_load_use();
    logic s;
    int   stalls = 0;
    step(7'd3, 1'b1, 5'd1, 5'd0, 5'd7, 1'b0, s);
    for (int i = 0; i < 3; i++) begin
      step(7'd51, 1'b1, 5'd2, 5'd7, 5'd8, 1'b0, s);
      if (s) stalls++;
      if (i == 0) begin
        tests_run++;
        if ({bus.ALUOp_o, bus.ALUSrc_o, bus.Branch_o, bus.EX_rd_o} !== '0) begin
          failures++;
          $display("FAIL load_use_bubble: got aluop=%b rd=%0d want 0/0", bus.ALUOp_o, bus.EX_rd_o);
        end
      end else if (i == 1) begin
        tests_run++;
        if ({bus.ALUOp_o, bus.EX_rd_o} !== {2'b10, 5'd8}) begin
          failures++;
          $display("FAIL load_use_late_r: got aluop=%b rd=%0d want 10/8", bus.ALUOp_o, bus.EX_rd_o);
        end
      end
    end
    tests_run++;
    if (stalls != 1) begin
      failures++;
      $display("FAIL load_use_stall_cycles: got %0d want 1", stalls);
    end
  endtask

  task automatic test_no_false_hazard();
    logic s;
    step(7'd3, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, s);
    step(7'd51, 1'b1, 5'd0, 5'd1, 5'd9, 1'b0, s);
    tests_run++;
    if (s !== 1'b0) begin failures++; $display("FAIL hazard_rd0: got stall=%b want 0", s); end
    step(7'd3, 1'b1, 5'd1, 5'd0, 5'd7, 1'b0, s);
    step(7'd19, 1'b1, 5'd2, 5'd7, 5'd9, 1'b0, s);
    tests_run++;
    if (s !== 1'b0) begin failures++; $display("FAIL hazard_unused_rs2: got stall=%b want 0", s); end
  endtask

  task automatic test_flush_vs_stall();
    logic s;
    step(7'd3, 1'b1, 5'd1, 5'd0, 5'd3, 1'b0, s);
    step(7'd99, 1'b1, 5'd3, 5'd4, 5'd0, 1'b1, s);
    tests_run++;
    if ({s, bus.Branch_o} !== 2'b00) begin
      failures++;
      $display("FAIL flush_vs_stall: got stall=%b branch=%b want 0/0", s, bus.Branch_o);
    end
  endtask

  task automatic test_invalid();
    logic s;
    step(7'h7F, 1'b1, 5'd1, 5'd2, 5'd10, 1'b0, s);
    step(7'd51, 1'b0, 5'd1, 5'd2, 5'd11, 1'b0, s);
    for (int i = 0; i < 3; i++) step(7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, s);
  endtask

  task automatic test_reset_midop();
    logic s;
    step(7'd3, 1'b1, 5'd1, 5'd0, 5'd4, 1'b0, s);
    step(7'd51, 1'b1, 5'd2, 5'd2, 5'd5, 1'b0, s);
    @(negedge clk);
    rst = 1'b1;
    drive(7'd51, 1'b1, 5'd5, 5'd5, 5'd6, 1'b1);
    @(posedge clk);
    #1;
    tests_run++;
    if ({bus.MemRead_o, bus.RegWrite_o, bus.MEM_RegWrite_o, bus.ALUOp_o, bus.EX_rd_o} !== '0) begin
      failures++;
      $display("FAIL reset_midop: got memread=%b regwrite=%b mem_rw=%b aluop=%b ex_rd=%0d want 0",
               bus.MemRead_o, bus.RegWrite_o, bus.MEM_RegWrite_o, bus.ALUOp_o, bus.EX_rd_o);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    sb_clear();
    step(7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, s);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [6] = '{7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'h7F};
    logic       s;
    for (int i = 0; i < 60; i++) begin
      step(ops[$urandom_range(0, 5)], ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), s);
    end
  endtask

`ifdef CTRL_PERF_CNT_EN
  task automatic test_perf_cnt();
    logic s;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step(7'd3, 1'b1, 5'd1, 5'd0, 5'd7, 1'b0, s);
      step(7'd51, 1'b1, 5'd7, 5'd2, 5'd8, 1'b0, s);
      step(7'd51, 1'b1, 5'd7, 5'd2, 5'd8, 1'b0, s);
    end
    step(7'd51, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, s);
    step(7'd19, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, s);
    tests_run++;
    if ({bus.StallCnt_o, bus.FlushCnt_o} !== {32'd3, 32'd2}) begin
      failures++;
      $display("FAIL perf_counts: got stall=%0d flush=%0d want 3/2", bus.StallCnt_o, bus.FlushCnt_o);
    end
    apply_reset();
    tests_run++;
    if ({bus.StallCnt_o, bus.FlushCnt_o} !== 64'd0) begin
      failures++;
      $display("FAIL perf_reset: got stall=%0d flush=%0d want 0/0", bus.StallCnt_o, bus.FlushCnt_o);
    end
  endtask
`endif

  initial begin
    drive(7'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    sb_clear();
    test_reset();
    test_r_then_i();
    test_load_use();
    test_no_false_hazard();
    test_flush_vs_stall();
    test_invalid();
    test_reset_midop();
    test_back_to_back();
`ifdef CTRL_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Next-generation main control for the pipelined RISC-V core.
- Decodes the ID-stage opcode (R, I-ALU, load, store, branch) into a full control bundle.
- Carries that bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles on stall or flush, so the datapath reads stage-aligned control directly.

Parameters:
- REG_AW, 5, register-address width for rd/rs1/rs2.
- LOAD_USE_DET, 1, 1 = load-use detection active; 0 = Stall_o tied 0.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- Op_i  in  7  ID-stage opcode.
- Valid_i  in  1  ID holds a real instruction; 0 decodes as bubble.
- Rs1_i  in  REG_AW  ID-stage rs1.
- Rs2_i  in  REG_AW  ID-stage rs2.
- Rd_i  in  REG_AW  ID-stage rd.
- Flush_i  in  1  kill the ID-stage instruction (branch taken in EX).
- Stall_o  out  1  load-use stall request to PC/IF-ID (combinational).
- ALUOp_o  out  2  EX stage ALU operation class.
- ALUSrc_o  out  1  EX stage: 1 = immediate operand.
- Branch_o  out  1  EX stage branch.
- EX_rd_o  out  REG_AW  EX stage rd.
- MemRead_o  out  1  MEM stage load.
- MemWrite_o  out  1  MEM stage store.
- MEM_RegWrite_o  out  1  MEM stage RegWrite, for forwarding.
- MEM_rd_o  out  REG_AW  MEM stage rd.
- RegWrite_o  out  1  WB stage write enable.
- MemtoReg_o  out  1  WB stage: 1 = select load data.
- WB_rd_o  out  REG_AW  WB stage rd.

Behaviour:
- Clock clk_i, reset rst_i: one clock domain; reset is synchronous and active-high.
- Decode (combinational, ID), fields listed as ALUOp/ALUSrc/RegWrite/MemRead/MemWrite/MemtoReg/Branch:
  - 51 (R): 10/0/1/0/0/0/0; uses rs1 and rs2.
  - 19 (I-ALU): 11/1/1/0/0/0/0; uses rs1.
  - 3 (load): 00/1/1/1/0/1/0; uses rs1.
  - 35 (store): 00/1/0/0/1/0/0; uses rs1 and rs2.
  - 99 (branch): 01/0/0/0/0/0/1; uses rs1 and rs2.
  - Any other opcode, or Valid_i=0: all-zero bubble, no registers used. No value is held over from the previous cycle.
- Pipeline: ID/EX, EX/MEM and MEM/WB each advance every cycle and are never frozen. Each control signal appears 1, 2 or 3 cycles after ID, in its own stage.
- Load-use hazard (when LOAD_USE_DET=1), all of the following true:
  - ID/EX MemRead=1;
  - EX_rd_o != 0;
  - EX_rd_o equals Rs1_i or Rs2_i, counted only for registers the ID opcode uses;
  - Valid_i=1.
- Stall_o = hazard AND NOT Flush_i.
- ID/EX loads a bubble when Stall_o=1 or Flush_i=1; otherwise it loads the decoded bundle and Rd_i.
- Flush_i has priority over the hazard; a flushed instruction never stalls.
- Bubbles force every control bit and rd to 0, so no write can reach x0 or the rd of a killed instruction.
- Stores and branches do not write a register: their RegWrite=0, and EX_rd_o carries Rd_i unmodified, which is harmless.
- Reset: all stage registers go to 0 on the first rising edge with rst_i=1.
  - All outputs read 0 afterwards; Stall_o=0 because ID/EX MemRead=0.
  - Reset mid-operation discards in-flight instructions with no partial writes.
  - rst_i overrides Flush_i and the hazard.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined: adds outputs StallCnt_o[31:0] and FlushCnt_o[31:0].
  - StallCnt_o increments on each cycle with Stall_o=1; FlushCnt_o increments on each cycle with Flush_i=1.
  - Both reset to 0 on rst_i and saturate at 0xFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- R then I: Op_i=51, Rd=5, then Op_i=19, Rd=6, no hazards. Cycle+1: ALUOp=10, ALUSrc=0, EX_rd=5. Cycle+3: RegWrite=1, MemtoReg=0, WB_rd=5. Next cycle: ALUOp=11, ALUSrc=1.
- Load-use: load Rd=7, then R with Rs2=7. Stall_o=1 for exactly 1 cycle. ID/EX holds a bubble (all outputs 0 in EX). The R op reaches EX one cycle late with EX_rd=0 during the bubble.
- No false hazard:
  - load Rd=0, then R with Rs1=0 → Stall_o=0.
  - load Rd=7, then I-ALU with Rs2=7 (unused) → Stall_o=0.
- Flush vs stall: load Rd=3, then branch with Rs1=3 and Flush_i=1 in the same cycle. Stall_o=0, ID/EX gets a bubble, Branch_o=0 next cycle.
- Invalid/reset: Op_i=0x7F with Valid_i=1 → a bubble traverses all stages, no RegWrite. Asserting rst_i with a load in EX/MEM → MemRead_o=0 and RegWrite_o=0 on the next cycle.
- CTRL_PERF_CNT_EN: 3 stalls and 2 flushes → StallCnt_o=3, FlushCnt_o=2. rst_i → both 0.
